qarctan_demod: RTL and testbench

Parametrised fixed-point quadrature-arctangent engine with an optional FM discriminator front end.
- Accepts I/Q samples over a valid/ready handshake.
- When DEMOD_EN=1, forms conj(prev)*cur; otherwise uses the input directly.
- Computes a quantized angle with an internal iterative divider, applies a gain, and presents the result on a valid/ready output.
- Sits between the channel filter/decimator and the audio filters in the FM radio datapath.

---
 rtl/qarctan_demod.sv | 247 ++++++++++++++++++++++++
 tb/tb_qarctan_demod.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/qarctan_demod.sv
// Quadrature arctangent engine with optional conj(prev)*cur FM discriminator.
// The angle is approximated as QUAD -/+ QUAD1*(r-|i|)/(r+|i|), scaled by GAIN.
module qarctan_demod #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FRAC_BITS  = 10,
    parameter int unsigned DEMOD_EN   = 1,
    parameter int          GAIN       = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_real,
    input  logic signed [DATA_WIDTH-1:0] in_imag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         busy
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    localparam real PI      = 3.14159265358979323846;
    localparam int  QUAD1_I = $rtoi(PI / 4.0 * (2.0 ** FRAC_BITS) + 0.5);

    // QUAD3 is built from the rounded QUAD1 so the two quadrant bases stay
    // exactly three steps of the same constant apart (2412 at FRAC_BITS=10).
    localparam logic signed [PW-1:0] QUAD1_W = PW'(QUAD1_I);
    localparam logic signed [PW-1:0] QUAD3_W = PW'(3 * QUAD1_I);
    localparam logic signed [PW-1:0] GAIN_W  = PW'(GAIN);

    typedef enum logic [2:0] {
        IDLE,
        DEMOD,
        SETUP,
        DIVIDE,
        ANGLE,
        SCALE,
        OUTPUT
    } state_t;

    state_t                 state_q, state_d;
    logic signed [DW-1:0]   r_q, r_d;
    logic signed [DW-1:0]   i_q, i_d;
    logic signed [DW-1:0]   prev_real_q, prev_real_d;
    logic signed [DW-1:0]   prev_imag_q, prev_imag_d;
    logic [DW-1:0]          dvd_q, dvd_d;
    logic [DW-1:0]          den_q, den_d;
    logic [DW-1:0]          rem_q, rem_d;
    logic                   num_neg_q, num_neg_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic signed [DW-1:0]   angle_q, angle_d;
    logic signed [DW-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;

    logic signed [DW-1:0]   abs_i;
    logic signed [DW-1:0]   a_s;
    logic signed [DW-1:0]   num_s;
    logic signed [DW-1:0]   den_s;
    logic [DW:0]            rem_shift;
    logic [DW:0]            rem_diff;
    logic                   q_bit;
    logic signed [DW-1:0]   quot_s;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   ang_w;

    // Dequantize: shift right by FRAC_BITS, truncating toward zero.
    function automatic logic signed [PW-1:0] deq(input logic signed [PW-1:0] x);
        logic [PW-1:0] mag;
        mag = x[PW-1] ? PW'(-x) : PW'(x);
        mag = mag >> FRAC_BITS;
        return x[PW-1] ? -signed'(mag) : signed'(mag);
    endfunction

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            r_q         <= '0;
            i_q         <= '0;
            prev_real_q <= '0;
            prev_imag_q <= '0;
            dvd_q       <= '0;
            den_q       <= '0;
            rem_q       <= '0;
            num_neg_q   <= 1'b0;
            cnt_q       <= '0;
            angle_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            i_q         <= i_d;
            prev_real_q <= prev_real_d;
            prev_imag_q <= prev_imag_d;
            dvd_q       <= dvd_d;
            den_q       <= den_d;
            rem_q       <= rem_d;
            num_neg_q   <= num_neg_d;
            cnt_q       <= cnt_d;
            angle_q     <= angle_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        i_d         = i_q;
        prev_real_d = prev_real_q;
        prev_imag_d = prev_imag_q;
        dvd_d       = dvd_q;
        den_d       = den_q;
        rem_d       = rem_q;
        num_neg_d   = num_neg_q;
        cnt_d       = cnt_q;
        angle_d     = angle_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        abs_i       = '0;
        a_s         = '0;
        num_s       = '0;
        den_s       = '0;
        rem_shift   = '0;
        rem_diff    = '0;
        q_bit       = 1'b0;
        quot_s      = '0;
        prod        = '0;
        ang_w       = '0;

        case (state_q)
            IDLE: begin
                if (!clear && in_valid) begin
                    r_d     = in_real;
                    i_d     = in_imag;
                    state_d = (DEMOD_EN != 0) ? DEMOD : SETUP;
                end
            end

            DEMOD: begin
                r_d = DW'(deq(PW'(prev_real_q) * PW'(r_q)) + deq(PW'(prev_imag_q) * PW'(i_q)));
                i_d = DW'(deq(PW'(prev_real_q) * PW'(i_q)) - deq(PW'(prev_imag_q) * PW'(r_q)));
                prev_real_d = r_q;
                prev_imag_d = i_q;
                state_d     = SETUP;
            end

            SETUP: begin
                // a = |i|+1 keeps the denominator >= 1 for every input.
                abs_i = i_q[DW-1] ? -i_q : i_q;
                a_s   = abs_i + DW'(1);
                if (!r_q[DW-1]) begin
                    num_s = (r_q - a_s) <<< FRAC_BITS;
                    den_s = r_q + a_s;
                end else begin
                    num_s = (r_q + a_s) <<< FRAC_BITS;
                    den_s = a_s - r_q;
                end
                num_neg_d = num_s[DW-1];
                dvd_d     = num_s[DW-1] ? DW'(-num_s) : DW'(num_s);
                den_d     = DW'(den_s);
                rem_d     = '0;
                cnt_d     = CW'(DW - 1);
                state_d   = DIVIDE;
            end

            DIVIDE: begin
                // Restoring step; quotient bits shift into the dividend register.
                rem_shift = {rem_q, dvd_q[DW-1]};
                rem_diff  = rem_shift - {1'b0, den_q};
                if (rem_shift >= {1'b0, den_q}) begin
                    rem_d = rem_diff[DW-1:0];
                    q_bit = 1'b1;
                end else begin
                    rem_d = rem_shift[DW-1:0];
                end
                dvd_d = {dvd_q[DW-2:0], q_bit};
                if (cnt_q == '0) begin
                    state_d = ANGLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            ANGLE: begin
                quot_s = num_neg_q ? -signed'(dvd_q) : signed'(dvd_q);
                if (r_q != '0 || i_q != '0) begin
                    prod  = QUAD1_W * PW'(quot_s);
                    ang_w = (r_q[DW-1] ? QUAD3_W : QUAD1_W) - deq(prod);
                    if (i_q[DW-1]) begin
                        ang_w = -ang_w;
                    end
                end
                angle_d = DW'(ang_w);
                state_d = SCALE;
            end

            SCALE: begin
                prod        = GAIN_W * PW'(angle_q);
                out_data_d  = DW'(deq(prod));
                out_valid_d = 1'b1;
                state_d     = OUTPUT;
            end

            OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // clear always forgets the previous sample and abandons any work.
        if (clear) begin
            prev_real_d = '0;
            prev_imag_d = '0;
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_qarctan_demod.sv
// Directed bench for qarctan_demod across four parameter sets.
//   u0: DW=32 plain arctan, gain 1024   u1: DW=32 discriminator, gain 1024
//   u2: DW=24 plain arctan, gain 2048   u3: DW=32 plain arctan, gain 2048
module tb_qarctan_demod;

    logic clock;
    logic reset;
    logic clear     [4];
    logic in_valid  [4];
    logic out_ready [4];
    logic in_ready  [4];
    logic out_valid [4];
    logic busy      [4];
    logic signed [31:0] in_real [4];
    logic signed [31:0] in_imag [4];
    logic signed [31:0] od0, od1, od3;
    logic signed [23:0] od2;

    int n_cmp;
    int n_err;

    int vr[5] = '{1024, 0, 0, -1024, 0};
    int vi[5] = '{0, 1024, -1024, 0, 0};
    int ve[5] = '{2, 1608, -1608, 3214, 0};

    qarctan_demod #(.DATA_WIDTH(32), .FRAC_BITS(10), .DEMOD_EN(0), .GAIN(1024)) u0 (
        .clock(clock), .reset(reset), .clear(clear[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_real(in_real[0]), .in_imag(in_imag[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(od0), .busy(busy[0]));

    qarctan_demod #(.DATA_WIDTH(32), .FRAC_BITS(10), .DEMOD_EN(1), .GAIN(1024)) u1 (
        .clock(clock), .reset(reset), .clear(clear[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_real(in_real[1]), .in_imag(in_imag[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(od1), .busy(busy[1]));

    qarctan_demod #(.DATA_WIDTH(24), .FRAC_BITS(10), .DEMOD_EN(0), .GAIN(2048)) u2 (
        .clock(clock), .reset(reset), .clear(clear[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_real(in_real[2][23:0]), .in_imag(in_imag[2][23:0]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(od2), .busy(busy[2]));

    qarctan_demod #(.DATA_WIDTH(32), .FRAC_BITS(10), .DEMOD_EN(0), .GAIN(2048)) u3 (
        .clock(clock), .reset(reset), .clear(clear[3]),
        .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_real(in_real[3]), .in_imag(in_imag[3]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .out_data(od3), .busy(busy[3]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic signed [31:0] rd_data(input int idx);
        case (idx)
            0:       return od0;
            1:       return od1;
            2:       return 32'(od2);
            default: return od3;
        endcase
    endfunction

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Send one sample, wait for the result, check latency and value, then drain.
    task automatic run_sample(input int idx, input int re, input int im,
                              input int exp_out, input int exp_lat, input string tag);
        int lat;
        @(negedge clock);
        check({tag, ".rdy"}, in_ready[idx], 1);
        in_real[idx]  = re;
        in_imag[idx]  = im;
        in_valid[idx] = 1'b1;
        @(posedge clock);
        #1;
        in_valid[idx] = 1'b0;
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!out_valid[idx] && lat < 100);
        check({tag, ".vld"}, out_valid[idx], 1);
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".data"}, rd_data(idx), exp_out);
        check({tag, ".rdy_lo"}, in_ready[idx], 0);
        if (out_ready[idx]) begin
            @(posedge clock);
            #1;
            check({tag, ".drain"}, out_valid[idx], 0);
            check({tag, ".idle"}, in_ready[idx], 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        n_cmp = 0;
        n_err = 0;
        for (int k = 0; k < 4; k++) begin
            clear[k]     = 1'b0;
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            in_real[k]   = '0;
            in_imag[k]   = '0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst.in_ready", in_ready[0], 1);
        check("rst.out_valid", out_valid[0], 0);
        check("rst.out_data", rd_data(0), 0);
        check("rst.busy", busy[0], 0);
        @(negedge clock);
        reset = 1'b0;

        // Plain arctan on the four axes and the origin.
        for (int k = 0; k < 5; k++) begin
            run_sample(0, vr[k], vi[k], ve[k], 35, $sformatf("axis%0d", k));
        end

        // Discriminator: first sample sees prev=(0,0); then a +90 degree step.
        run_sample(1, 1024, 0, 0, 36, "dm0");
        run_sample(1, 0, 1024, 1608, 36, "dm1");

        // clear together with in_valid in IDLE: sample is dropped, prev zeroed.
        @(negedge clock);
        clear[1]    = 1'b1;
        in_valid[1] = 1'b1;
        in_real[1]  = 0;
        in_imag[1]  = 1024;
        @(posedge clock);
        #1;
        check("clr_win.busy", busy[1], 0);
        check("clr_win.rdy", in_ready[1], 1);
        @(negedge clock);
        clear[1]    = 1'b0;
        in_valid[1] = 1'b0;
        run_sample(1, 0, 1024, 0, 36, "dm_clr");

        // Backpressure: hold the result for 10 cycles while in_valid is high.
        out_ready[0] = 1'b0;
        run_sample(0, 0, 1024, 1608, 35, "bp");
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            in_valid[0] = 1'b1;
            in_real[0]  = 5000;
            in_imag[0]  = 7;
            @(posedge clock);
            #1;
            check($sformatf("bp.hold%0d.data", k), rd_data(0), 1608);
            check($sformatf("bp.hold%0d.rdy", k), in_ready[0], 0);
        end
        @(negedge clock);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clock);
        #1;
        check("bp.release.vld", out_valid[0], 0);
        check("bp.release.rdy", in_ready[0], 1);
        @(posedge clock);
        #1;
        check("bp.no_accept.busy", busy[0], 0);

        // Gain 2048 at two data widths.
        run_sample(3, 0, 1024, 3216, 35, "gain32");
        run_sample(2, 0, 1024, 3216, 27, "gain24");

        // clear mid-DIVIDE aborts with no result.
        @(negedge clock);
        in_valid[0] = 1'b1;
        in_real[0]  = 1024;
        in_imag[0]  = 0;
        @(posedge clock);
        #1;
        in_valid[0] = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("abort.busy_before", busy[0], 1);
        clear[0] = 1'b1;
        @(posedge clock);
        #1;
        check("abort.busy", busy[0], 0);
        check("abort.rdy", in_ready[0], 1);
        @(negedge clock);
        clear[0] = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (out_valid[0]) pulses++;
        end
        check("abort.no_pulse", pulses, 0);
        run_sample(0, 0, 1024, 1608, 35, "post_clr");

        // Asynchronous reset mid-DIVIDE.
        @(negedge clock);
        in_valid[0] = 1'b1;
        in_real[0]  = 0;
        in_imag[0]  = -1024;
        @(posedge clock);
        #1;
        in_valid[0] = 1'b0;
        repeat (10) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("arst.out_data", rd_data(0), 0);
        check("arst.busy", busy[0], 0);
        check("arst.rdy", in_ready[0], 1);
        check("arst.vld", out_valid[0], 0);
        @(negedge clock);
        reset = 1'b0;
        run_sample(0, 0, -1024, -1608, 35, "post_rst");
        // prev was (0,1024) before reset; a stale prev would give 2 here.
        run_sample(1, 0, 1024, 0, 36, "post_rst_dm");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
